nano4k_flash_sequencer: RTL
===========================

# nano4k_flash_sequencer

Operation-level front end for the `nano4k_spi_flash` byte controller. It accepts one high-level request (read, page program, page erase, read ID) from a host and expands it into the required flash command sequence: WREN, the main command, and RDSR polling until WIP clears. It drives the controller's `interfaceEnable_n`/`fCommand`/`fAddress`/`fData_WR` inputs and consumes its `RdDataValid`/`WrDataReady` strobes. It replaces hand-scheduled command timelines in top-level designs.

## Interface
- `GAP_CYCLES`, 4: cycles `interfaceEnable_n` is held high between consecutive commands.
- `NODATA_CYCLES`, 40: cycles enable is held low for commands with no data phase (WREN, PE).
- `POLL_MAX`, 65535: maximum RDSR polls before timeout.
- `serialClk` in 1: single clock, same as the controller's.
- `reset` in 1: synchronous, active-high.
- `op_valid` in 1: request present.
- `op_ready` out 1: sequencer idle; request accepted when `op_valid && op_ready`.
- `op_code` in 2: 0 READ (FREAD), 1 PROGRAM (PP), 2 ERASE (PE), 3 READ_ID (RDID).
- `op_addr` in 22: flash byte address.
- `op_len` in 8: byte count minus 1 (1..256); ignored for ERASE; READ_ID is fixed at 3 bytes.
- `wr_valid`, `wr_ready`, `wr_data[7:0]`: host program-data stream into the prefetch FIFO.
- `rd_valid` out 1, `rd_data` out 8: read/ID bytes, one-cycle pulse per byte.
- `done` out 1: one-cycle pulse at the end of an operation.
- `err` out 2: valid with `done`; bit0 poll timeout, bit1 write underrun.
- `interfaceEnable_n`, `fCommand[7:0]`, `fAddress[21:0]`, `fData_WR[7:0]` out: to the controller.
- `fData_RD[7:0]`, `RdDataValid`, `WrDataReady` in: from the controller.

## Operation
- States: IDLE, LOAD, RUN, GAP, CHECK, FINISH. A sub-step register selects the current command: WREN, MAIN, or POLL.
- **IDLE**
  - `op_ready=1`.
  - On accept: latch code, address and length.
  - PROGRAM and ERASE go to LOAD(WREN). READ and READ_ID go to LOAD(MAIN).
- **LOAD** (one cycle, enable high)
  - Register `fCommand` and `fAddress`. `fData_WR` takes the FIFO head.
  - Next state is RUN with enable low.
- **RUN**
  - WREN/PE: hold enable low for `NODATA_CYCLES`.
  - FREAD/RDID: forward each `RdDataValid` as `rd_valid`/`rd_data` and count bytes. Raise enable the cycle after the last byte.
  - PP: on each `WrDataReady`, pop the FIFO and present the next byte. Raise enable after the len-th strobe.
  - RDSR: capture the first `RdDataValid` byte, then raise enable.
- **GAP**
  - Hold enable high for `GAP_CYCLES`.
  - Next command: after WREN → MAIN; after PP/PE → POLL; after POLL → CHECK; after FREAD/RDID → FINISH.
- **CHECK**
  - Status bit0=0 → FINISH.
  - Status bit0=1 and polls < `POLL_MAX` → LOAD(POLL).
  - Otherwise set `err[0]` and go to FINISH.
- **FINISH**: pulse `done` with `err`, then return to IDLE.
- **Boundary rules**
  - FIFO empty when `WrDataReady` arrives: send 0xFF (no-program value), set `err[1]`, and continue. The controller cannot stall.
  - PP addresses are not split at 256-byte page boundaries. The flash wraps within the page; this is documented behaviour.
  - `wr_ready` is high whenever the FIFO is not full, including in IDLE, so the host may prefill.
  - `op_valid` is ignored while not IDLE.
- **Reset**
  - Takes effect the next cycle regardless of state; the FIFO is flushed.
  - Output values: `interfaceEnable_n=1`, `fCommand=0`, `fAddress=0`, `fData_WR=0xFF`, `op_ready=0` (1 from the first post-reset cycle), `rd_valid=0`, `done=0`, `err=0`, `wr_ready=0` (1 from the first post-reset cycle).

## Timing
- Accept at cycle N: LOAD at N+1, enable low at N+2.
- `fCommand`/`fAddress` change only in LOAD, when enable is high.
- `rd_valid` has 1-cycle latency from `RdDataValid`.
- Byte and poll counters are 9 and 16 bits, compared with `op_len+1` and `POLL_MAX`.
- Per-command overhead: 1 LOAD + `GAP_CYCLES`.
- ERASE with zero busy polls: 1 + (1+NODATA) + GAP + (1+NODATA) + GAP + (1+RDSR) + GAP + CHECK + FINISH.

## Structure
- Package `nano4k_flash_pkg`:
  - Opcodes: WREN 0x06, RDSR 0x05, PP 0x02, PE 0x81, FREAD 0x0B, RDID 0x9F.
  - `op_code` enum, state enum, err bit indices.
  - Shared with the controller and the tops.
- Sub-module `nano4k_byte_fifo`:
  - 8-bit wide, 4 deep, synchronous reset.
  - Signals: push, pop, empty, full, head.

## Test plan
- **READ**: op_addr 0x00A001, len 3 (op_len=2), behavioural flash returns 0x11,0x22,0x33 → FREAD 0x0B at address 0xA001; three `rd_valid` with those bytes; `done` with `err=0`; no WREN issued.
- **PROGRAM**: 2 bytes 0x5A,0xA5 prefilled; flash reports WIP=1 for 3 polls → command order WREN, PP, RDSR×4; `fData_WR` sequence 0x5A,0xA5; `done` with `err=0`.
- **Underrun**: PROGRAM with len 4 and only 2 bytes supplied → bytes 3–4 sent as 0xFF; `err=2'b10`.
- **Timeout**: ERASE at 0x001000 with `POLL_MAX=5` and WIP stuck at 1 → exactly 5 RDSR; `err=2'b01`.
- **Reset mid-PP**: assert `reset` during RUN → `interfaceEnable_n=1` next cycle; FIFO empty; `op_ready=1` after release; no `done` pulse.
- **READ_ID**: flash returns 0x85,0x60,0x16 → three `rd_valid`; `op_valid` pulsed while busy is ignored.

Source files
------------

// File: rtl/nano4k_flash_pkg.sv
// Shared opcodes, request codes and sequencer state types for the nano4k flash path.
package nano4k_flash_pkg;

  localparam logic [7:0] CMD_WREN  = 8'h06;
  localparam logic [7:0] CMD_RDSR  = 8'h05;
  localparam logic [7:0] CMD_PP    = 8'h02;
  localparam logic [7:0] CMD_PE    = 8'h81;
  localparam logic [7:0] CMD_FREAD = 8'h0B;
  localparam logic [7:0] CMD_RDID  = 8'h9F;

  typedef enum logic [1:0] {
    OP_READ    = 2'd0,
    OP_PROGRAM = 2'd1,
    OP_ERASE   = 2'd2,
    OP_READ_ID = 2'd3
  } op_code_t;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RUN, S_GAP, S_CHECK, S_FINISH
  } state_t;

  typedef enum logic [1:0] {
    STEP_WREN, STEP_MAIN, STEP_POLL
  } step_t;

  localparam int ERR_TIMEOUT  = 0;
  localparam int ERR_UNDERRUN = 1;

  function automatic logic [7:0] main_cmd(input op_code_t c);
    case (c)
      OP_READ:    return CMD_FREAD;
      OP_PROGRAM: return CMD_PP;
      OP_ERASE:   return CMD_PE;
      default:    return CMD_RDID;
    endcase
  endfunction

endpackage

// File: rtl/nano4k_byte_fifo.sv
// Four-entry byte FIFO holding host program data ahead of the PP data phase.
module nano4k_byte_fifo (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic       empty,
  output logic       full,
  output logic [7:0] head
);

  logic [7:0] mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;
  logic       push_ok;
  logic       pop_ok;

  assign empty   = (count == 3'd0);
  assign full    = (count == 3'd4);
  assign head    = mem[rd_ptr];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop_ok) rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b00, push_ok} - {2'b00, pop_ok};
    end
  end

endmodule

// File: rtl/nano4k_flash_sequencer.sv
// Expands one host flash request into WREN / main command / RDSR polling for the
// nano4k_spi_flash byte controller, with a small prefetch FIFO for program data.
module nano4k_flash_sequencer
  import nano4k_flash_pkg::*;
#(
  parameter int GAP_CYCLES    = 4,
  parameter int NODATA_CYCLES = 40,
  parameter int POLL_MAX      = 65535
) (
  input  logic        serialClk,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [1:0]  op_code,
  input  logic [21:0] op_addr,
  input  logic [7:0]  op_len,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [7:0]  wr_data,
  output logic        rd_valid,
  output logic [7:0]  rd_data,
  output logic        done,
  output logic [1:0]  err,
  output logic        interfaceEnable_n,
  output logic [7:0]  fCommand,
  output logic [21:0] fAddress,
  output logic [7:0]  fData_WR,
  input  logic [7:0]  fData_RD,
  input  logic        RdDataValid,
  input  logic        WrDataReady,
  output state_t      dbg_state
);

  localparam logic [15:0] GAP_LAST    = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] NODATA_LAST = 16'(NODATA_CYCLES - 1);
  localparam logic [15:0] POLL_LIMIT  = 16'(POLL_MAX);

  state_t     state;
  step_t      step;
  op_code_t   code;
  op_code_t   req_code;
  logic [21:0] addr;
  logic [7:0]  len;
  logic [15:0] cnt;
  logic [8:0]  byte_cnt;
  logic [8:0]  byte_next;
  logic [8:0]  len_p1;
  logic [15:0] poll_cnt;
  logic        wip;
  logic        is_nodata;
  logic        is_pp;
  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_empty;
  logic        fifo_full;
  logic [7:0]  fifo_head;

  // Handshakes: a request transfers on a rising edge where op_valid && op_ready;
  // a host byte transfers where wr_valid && wr_ready. Both readies drop during reset.
  assign op_ready  = (state == S_IDLE) && !reset;
  assign wr_ready  = !fifo_full && !reset;
  assign fifo_push = wr_valid && wr_ready;
  assign dbg_state = state;
  assign req_code  = op_code_t'(op_code);

  assign is_nodata = (step == STEP_WREN) || ((step == STEP_MAIN) && (code == OP_ERASE));
  assign is_pp     = (step == STEP_MAIN) && (code == OP_PROGRAM);
  assign byte_next = byte_cnt + 9'd1;
  assign len_p1    = {1'b0, len} + 9'd1;
  assign fifo_pop  = (state == S_RUN) && is_pp && WrDataReady && !fifo_empty;

  nano4k_byte_fifo u_fifo (
    .clk   (serialClk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (wr_data),
    .empty (fifo_empty),
    .full  (fifo_full),
    .head  (fifo_head)
  );

  always_ff @(posedge serialClk) begin
    if (reset) begin
      state             <= S_IDLE;
      step              <= STEP_WREN;
      code              <= OP_READ;
      addr              <= '0;
      len               <= '0;
      cnt               <= '0;
      byte_cnt          <= '0;
      poll_cnt          <= '0;
      wip               <= 1'b0;
      interfaceEnable_n <= 1'b1;
      fCommand          <= '0;
      fAddress          <= '0;
      fData_WR          <= 8'hFF;
      rd_valid          <= 1'b0;
      rd_data           <= '0;
      done              <= 1'b0;
      err               <= '0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      unique case (state)
        S_IDLE: if (op_valid) begin
          code     <= req_code;
          addr     <= op_addr;
          len      <= (req_code == OP_READ_ID) ? 8'd2 : op_len;
          err      <= '0;
          poll_cnt <= '0;
          step     <= ((req_code == OP_PROGRAM) || (req_code == OP_ERASE)) ? STEP_WREN : STEP_MAIN;
          state    <= S_LOAD;
        end
        S_LOAD: begin
          unique case (step)
            STEP_WREN: fCommand <= CMD_WREN;
            STEP_POLL: fCommand <= CMD_RDSR;
            default:   fCommand <= main_cmd(code);
          endcase
          fAddress          <= addr;
          fData_WR          <= fifo_empty ? 8'hFF : fifo_head;
          if (step == STEP_POLL) poll_cnt <= poll_cnt + 16'd1;
          cnt               <= '0;
          byte_cnt          <= '0;
          interfaceEnable_n <= 1'b0;
          state             <= S_RUN;
        end
        S_RUN: begin
          if (is_nodata) begin
            if (cnt == NODATA_LAST) begin
              cnt               <= '0;
              interfaceEnable_n <= 1'b1;
              state             <= S_GAP;
            end else begin
              cnt <= cnt + 16'd1;
            end
          end else if (step == STEP_POLL) begin
            if (RdDataValid) begin
              wip               <= fData_RD[0];
              interfaceEnable_n <= 1'b1;
              state             <= S_GAP;
            end
          end else if (is_pp) begin
            // The controller cannot stall, so an empty FIFO sends 0xFF and is flagged.
            if (WrDataReady) begin
              if (fifo_empty) err[ERR_UNDERRUN] <= 1'b1;
              byte_cnt <= byte_next;
              if (byte_next == len_p1) begin
                interfaceEnable_n <= 1'b1;
                state             <= S_GAP;
              end
            end else begin
              fData_WR <= fifo_empty ? 8'hFF : fifo_head;
            end
          end else if (RdDataValid) begin
            rd_valid <= 1'b1;
            rd_data  <= fData_RD;
            byte_cnt <= byte_next;
            if (byte_next == len_p1) begin
              interfaceEnable_n <= 1'b1;
              state             <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt <= '0;
            unique case (step)
              STEP_WREN: begin
                step  <= STEP_MAIN;
                state <= S_LOAD;
              end
              STEP_MAIN: begin
                if ((code == OP_PROGRAM) || (code == OP_ERASE)) begin
                  step  <= STEP_POLL;
                  state <= S_LOAD;
                end else begin
                  done  <= 1'b1;
                  state <= S_FINISH;
                end
              end
              default: state <= S_CHECK;
            endcase
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        S_CHECK: begin
          if (!wip) begin
            done  <= 1'b1;
            state <= S_FINISH;
          end else if (poll_cnt < POLL_LIMIT) begin
            step  <= STEP_POLL;
            state <= S_LOAD;
          end else begin
            err[ERR_TIMEOUT] <= 1'b1;
            done             <= 1'b1;
            state            <= S_FINISH;
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule
